// File: rtl/svc_uart_tx_arb.sv
// svc_uart_tx_arb
// Arbitrates several byte-stream requesters onto one shared UART transmitter.
// A requester is granted ownership by round-robin and, with LINE_LOCK=1, keeps
// it until it sends a newline (0x0A) or stalls mid-line for MAX_HOLD cycles.
// With LINE_LOCK=0 ownership is released after every byte.
//
// Handshake semantics (all valid/ready pairs on this block):
//   A transfer happens on a rising edge where valid and ready are both high.
//   A source holds valid and its data stable until the transfer; valid never
//   waits on ready. ready may depend combinationally on the sink's state.
//   Here req_ready[owner] = !tx_valid || tx_ready, so the one-entry output
//   register can take a new byte in the same cycle it hands one to the UART.
module svc_uart_tx_arb #(
  parameter int NUM_REQ   = 2,
  parameter int LINE_LOCK = 1,
  parameter int MAX_HOLD  = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   hold_timeout,
  output logic                   dbg_state
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int HW = ($clog2(MAX_HOLD) > 8) ? $clog2(MAX_HOLD) : 8;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  // Registered state
  state_t            r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [IW-1:0]     r_owner;
  logic [IW-1:0]     r_last_owner;
  logic              r_tx_valid;
  logic [7:0]        r_tx_data;
  logic [HW-1:0]     r_hold_cnt;
  logic              r_hold_timeout;

  // Combinational helpers
  logic              w_out_free;
  logic [NUM_REQ-1:0] w_req_ready;
  logic              w_accept;
  logic [7:0]        w_own_data;
  logic              w_is_nl;
  logic              w_hold_hit;
  logic              w_release;
  logic              w_rr_found;
  logic [IW-1:0]     w_rr_idx;
  logic [IW-1:0]     w_cand;
  logic [NUM_REQ-1:0] w_rr_onehot;

  // Output register can take a byte when empty or draining this cycle.
  assign w_out_free  = !r_tx_valid || tx_ready;
  assign w_req_ready = r_grant & {NUM_REQ{w_out_free}};
  assign w_accept    = |(req_valid & w_req_ready);
  assign w_is_nl     = (w_own_data == 8'h0A);

  // Stall limit reached; a byte accepted in the same cycle takes precedence.
  assign w_hold_hit  = (LINE_LOCK != 0) && (r_state == S_OWN) && !w_accept &&
                       (r_hold_cnt == HOLD_LIM);

  // Ownership ends on the edge after the releasing byte or the stall limit.
  assign w_release   = (r_state == S_OWN) &&
                       ((w_accept && ((LINE_LOCK == 0) || w_is_nl)) || w_hold_hit);

  // Select the current owner's byte lane.
  always_comb begin
    w_own_data = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == IW'(i)) begin
        w_own_data = req_data[8*i +: 8];
      end
    end
  end

  // Round-robin search starting just after the last owner, with wrap.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_cand     = r_last_owner;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = (w_cand == LAST_IDX) ? '0 : w_cand + IW'(1);
      if (!w_rr_found && req_valid[w_cand]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_cand;
      end
    end
  end

  // Decode the round-robin winner into a one-hot grant vector.
  always_comb begin
    w_rr_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rr_onehot[i] = (w_rr_idx == IW'(i));
    end
  end

  // One-entry output stage; drains toward the UART independently of grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else if (w_accept) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= w_own_data;
    end else if (tx_ready) begin
      r_tx_valid <= 1'b0;
    end
  end

  // Ownership FSM with grant, hold counter and timeout pulse as registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_grant        <= '0;
      r_owner        <= '0;
      r_last_owner   <= LAST_IDX;
      r_hold_cnt     <= '0;
      r_hold_timeout <= 1'b0;
    end else begin
      r_hold_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rr_found) begin
            r_state    <= S_OWN;
            r_grant    <= w_rr_onehot;
            r_owner    <= w_rr_idx;
            r_hold_cnt <= '0;
          end
        end
        S_OWN: begin
          if (w_release) begin
            r_state        <= S_IDLE;
            r_grant        <= '0;
            r_last_owner   <= r_owner;
            r_hold_cnt     <= '0;
            r_hold_timeout <= w_hold_hit;
          end else if (w_accept) begin
            r_hold_cnt <= '0;
          end else if (LINE_LOCK != 0) begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = w_req_ready;
  assign tx_valid     = r_tx_valid;
  assign tx_data      = r_tx_data;
  assign grant        = r_grant;
  assign hold_timeout = r_hold_timeout;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_svc_uart_tx_arb.sv
// tb_svc_uart_tx_arb
// Directed bench: instance A (2 requesters, line lock, MAX_HOLD=16) and
// instance B (3 requesters, per-byte release). Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
module tb_svc_uart_tx_arb;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- instance A signals ----------------
  logic [1:0]  a_req_valid;
  logic [15:0] a_req_data;
  logic [1:0]  a_req_ready;
  logic        a_tx_valid;
  logic [7:0]  a_tx_data;
  logic        a_tx_ready;
  logic [1:0]  a_grant;
  logic        a_hold_timeout;
  logic        a_dbg_state;

  // ---------------- instance B signals ----------------
  logic [2:0]  b_req_valid;
  logic [23:0] b_req_data;
  logic [2:0]  b_req_ready;
  logic        b_tx_valid;
  logic [7:0]  b_tx_data;
  logic        b_tx_ready;
  logic [2:0]  b_grant;
  logic        b_hold_timeout;
  logic        b_dbg_state;

  svc_uart_tx_arb #(.NUM_REQ(2), .LINE_LOCK(1), .MAX_HOLD(16)) u_dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (a_req_valid),
    .req_data     (a_req_data),
    .req_ready    (a_req_ready),
    .tx_valid     (a_tx_valid),
    .tx_data      (a_tx_data),
    .tx_ready     (a_tx_ready),
    .grant        (a_grant),
    .hold_timeout (a_hold_timeout),
    .dbg_state    (a_dbg_state)
  );

  svc_uart_tx_arb #(.NUM_REQ(3), .LINE_LOCK(0), .MAX_HOLD(256)) u_dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (b_req_valid),
    .req_data     (b_req_data),
    .req_ready    (b_req_ready),
    .tx_valid     (b_tx_valid),
    .tx_data      (b_tx_data),
    .tx_ready     (b_tx_ready),
    .grant        (b_grant),
    .hold_timeout (b_hold_timeout),
    .dbg_state    (b_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_a_q[$];
  logic [7:0] exp_b_q[$];

  // Byte-stream sources for instance A (byte k of a stream in bits [8k+7:8k]).
  logic [63:0] a_bytes [2];
  int          a_len   [2];
  int          a_ptr   [2];
  logic [1:0]  a_en;
  logic [1:0]  a_acc;

  // Hand-computed expected grant sequences.
  logic [1:0] t1_grant [9]  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00};
  logic [1:0] t1_ready [9]  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00};
  logic [1:0] t4_grant [7]  = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
  logic [2:0] t5_grant [10] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000,
                                3'b100, 3'b000, 3'b001, 3'b000, 3'b010};

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_a(input int i, input int n, input logic [63:0] b);
    a_bytes[i] = b;
    a_len[i]   = n;
    a_ptr[i]   = 0;
  endtask

  task automatic drive_a();
    for (int i = 0; i < 2; i++) begin
      if (a_en[i] && (a_ptr[i] < a_len[i])) begin
        a_req_valid[i]        = 1'b1;
        a_req_data[8*i +: 8]  = a_bytes[i][8*a_ptr[i] +: 8];
      end else begin
        a_req_valid[i]        = 1'b0;
        a_req_data[8*i +: 8]  = 8'h00;
      end
    end
  endtask

  // Falling-edge sample: record handshakes and check delivered UART bytes.
  task automatic sample();
    @(negedge clk);
    a_acc = a_req_valid & a_req_ready;
    if (a_tx_valid && a_tx_ready) begin
      if (exp_a_q.size() == 0) check("a_tx_extra_byte", exp_a_q.size(), 1);
      else                     check("a_tx_data", a_tx_data, exp_a_q.pop_front());
    end
    if (b_tx_valid && b_tx_ready) begin
      if (exp_b_q.size() == 0) check("b_tx_extra_byte", exp_b_q.size(), 1);
      else                     check("b_tx_data", b_tx_data, exp_b_q.pop_front());
    end
  endtask

  // Step past the rising edge and advance sources that transferred.
  task automatic advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (a_acc[i]) a_ptr[i]++;
    end
    a_acc = '0;
    drive_a();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n       = 1'b0;
    a_en        = 2'b00;
    a_acc       = 2'b00;
    a_tx_ready  = 1'b1;
    b_req_valid = 3'b000;
    b_req_data  = 24'h0;
    b_tx_ready  = 1'b1;
    load_a(0, 0, 64'h0);
    load_a(1, 0, 64'h0);
    drive_a();

    // Reset: both requesters "AB\n" already valid; outputs must stay idle.
    load_a(0, 3, 64'h0A4241);
    load_a(1, 3, 64'h0A4241);
    a_en = 2'b11;
    drive_a();
    for (int r = 0; r < 2; r++) begin
      sample();
      check($sformatf("rst_grant_%0d", r), a_grant, 2'b00);
      check($sformatf("rst_ready_%0d", r), a_req_ready, 2'b00);
      check($sformatf("rst_txv_%0d", r), a_tx_valid, 1'b0);
      check($sformatf("rst_txd_%0d", r), a_tx_data, 8'h00);
      check($sformatf("rst_to_%0d", r), a_hold_timeout, 1'b0);
      check($sformatf("rst_state_%0d", r), a_dbg_state, 1'b0);
      check($sformatf("rst_b_grant_%0d", r), b_grant, 3'b000);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // T1: two full lines, req0 first, one IDLE cycle between owners.
    exp_a_q.push_back(8'h41); exp_a_q.push_back(8'h42); exp_a_q.push_back(8'h0A);
    exp_a_q.push_back(8'h41); exp_a_q.push_back(8'h42); exp_a_q.push_back(8'h0A);
    for (int c = 0; c < 9; c++) begin
      sample();
      check($sformatf("t1_grant_c%0d", c), a_grant, t1_grant[c]);
      check($sformatf("t1_ready_c%0d", c), a_req_ready, t1_ready[c]);
      advance();
    end
    idle_cycles(3);

    // T2: single requester, UART stalls for 3 cycles on the second byte.
    load_a(0, 4, 64'h0A434241);
    load_a(1, 0, 64'h0);
    a_en = 2'b01;
    drive_a();
    exp_a_q.push_back(8'h41); exp_a_q.push_back(8'h42);
    exp_a_q.push_back(8'h43); exp_a_q.push_back(8'h0A);
    for (int d = 0; d < 10; d++) begin
      a_tx_ready = !((d >= 3) && (d <= 5));
      sample();
      if ((d >= 3) && (d <= 5)) begin
        check($sformatf("t2_stall_txv_d%0d", d), a_tx_valid, 1'b1);
        check($sformatf("t2_stall_txd_d%0d", d), a_tx_data, 8'h42);
        check($sformatf("t2_stall_ready_d%0d", d), a_req_ready, 2'b00);
      end
      check($sformatf("t2_grant_d%0d", d), a_grant, ((d >= 1) && (d <= 7)) ? 2'b01 : 2'b00);
      advance();
    end
    a_tx_ready = 1'b1;
    idle_cycles(2);

    // T3: req1 sends 'X', stalls, sends 'Y' exactly at the hold limit (byte
    // wins), stalls again until forced release; req0 waits with "Z\n".
    load_a(0, 2, 64'h0A5A);
    load_a(1, 3, 64'h0A5958);
    exp_a_q.push_back(8'h58); exp_a_q.push_back(8'h59); exp_a_q.push_back(8'h5A);
    exp_a_q.push_back(8'h0A); exp_a_q.push_back(8'h0A);
    for (int k = 0; k < 40; k++) begin
      logic [1:0] eg;
      a_en = {((k <= 1) || (k == 17) || (k >= 37)), 1'b1};
      drive_a();
      sample();
      if (k == 0)                      eg = 2'b00;
      else if (k <= 33)                eg = 2'b10;
      else if (k == 34)                eg = 2'b00;
      else if ((k == 35) || (k == 36)) eg = 2'b01;
      else if (k == 38)                eg = 2'b10;
      else                             eg = 2'b00;
      check($sformatf("t3_grant_k%0d", k), a_grant, eg);
      check($sformatf("t3_timeout_k%0d", k), a_hold_timeout, (k == 34));
      check($sformatf("t3_state_k%0d", k), a_dbg_state, (eg != 2'b00));
      advance();
    end
    idle_cycles(2);

    // T4: req0 finishes a line (last owner becomes 0), req1 is mid-line with
    // a byte stuck in the output stage when reset hits.
    load_a(0, 1, 64'h0A);
    load_a(1, 3, 64'h0A4241);
    a_en = 2'b11;
    drive_a();
    exp_a_q.push_back(8'h0A);
    for (int f = 0; f < 4; f++) begin
      sample();
      advance();
    end
    a_tx_ready = 1'b0;
    sample();
    check("t4_pre_txv", a_tx_valid, 1'b1);
    check("t4_pre_txd", a_tx_data, 8'h41);
    check("t4_pre_grant", a_grant, 2'b10);
    #2;
    rst_n = 1'b0;
    load_a(0, 2, 64'h0A4D);
    load_a(1, 2, 64'h0A4E);
    a_en  = 2'b11;
    a_acc = 2'b00;
    drive_a();
    #1;
    check("t4_async_grant", a_grant, 2'b00);
    check("t4_async_txv", a_tx_valid, 1'b0);
    check("t4_async_txd", a_tx_data, 8'h00);
    check("t4_async_ready", a_req_ready, 2'b00);
    for (int r = 0; r < 2; r++) begin
      sample();
      check($sformatf("t4_rst_grant_%0d", r), a_grant, 2'b00);
      check($sformatf("t4_rst_txv_%0d", r), a_tx_valid, 1'b0);
      check($sformatf("t4_rst_to_%0d", r), a_hold_timeout, 1'b0);
    end
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    a_tx_ready = 1'b1;
    exp_a_q.push_back(8'h4D); exp_a_q.push_back(8'h0A);
    exp_a_q.push_back(8'h4E); exp_a_q.push_back(8'h0A);
    for (int g = 0; g < 7; g++) begin
      sample();
      check($sformatf("t4_grant_g%0d", g), a_grant, t4_grant[g]);
      advance();
    end
    idle_cycles(2);

    // T5: instance B, three requesters always valid, one byte per grant.
    b_req_data  = {8'hC2, 8'hB1, 8'hA0};
    b_req_valid = 3'b111;
    exp_b_q.push_back(8'hA0); exp_b_q.push_back(8'hB1); exp_b_q.push_back(8'hC2);
    exp_b_q.push_back(8'hA0); exp_b_q.push_back(8'hB1);
    for (int h = 0; h < 10; h++) begin
      sample();
      check($sformatf("t5_grant_h%0d", h), b_grant, t5_grant[h]);
      advance();
      if (h == 9) b_req_valid = 3'b000;
    end
    idle_cycles(2);

    // ---------------- final report ----------------
    check("a_queue_drained", exp_a_q.size(), 0);
    check("b_queue_drained", exp_b_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/svc_uart_tx_arb.md
SVC_UART_TX_ARB -- requirements
Module: svc_uart_tx_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of byte-stream requesters (range 2..8).
REQ-002 SHALL have parameter LINE_LOCK, default 1; 1 = grant held until newline, 0 = grant released after each byte.
REQ-003 SHALL have parameter MAX_HOLD, default 256, idle cycles the owner may stall mid-line before forced release.
REQ-004 SHALL have clk  input  1  single clock; all logic on the rising edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have req_valid  input  NUM_REQ  per-requester byte-valid.
REQ-007 SHALL have req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-008 SHALL have req_ready  output  NUM_REQ  per-requester byte accepted when paired with req_valid.
REQ-009 SHALL have tx_valid  output  1  byte valid toward the shared UART transmitter.
REQ-010 SHALL have tx_data  output  8  byte toward the UART transmitter.
REQ-011 SHALL have tx_ready  input  1  UART transmitter accepts tx_data.
REQ-012 SHALL have grant  output  NUM_REQ  one-hot current owner; all-zero when no owner.
REQ-013 SHALL have hold_timeout  output  1  single-cycle pulse on forced release.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (no owner) and OWN (grant non-zero).
REQ-015 IDLE: if any req_valid, SHALL latch the owner by round-robin and enter OWN on the next edge; otherwise it SHALL remain in IDLE.
REQ-016 Round-robin SHALL search from (last_owner+1) mod NUM_REQ upward with wrap; last_owner SHALL reset to NUM_REQ-1, so requester 0 wins the first arbitration.
REQ-017 OWN: req_ready[owner] SHALL equal (!tx_valid || tx_ready); every other req_ready bit SHALL be 0.
REQ-018 In IDLE, all req_ready bits SHALL be 0.
REQ-019 An accepted byte (req_valid & req_ready on the owner) SHALL load tx_data and set tx_valid on the next edge: one-entry registered output stage.
REQ-020 tx_valid SHALL clear on tx_valid & tx_ready unless a new byte is accepted in the same cycle; back-to-back bytes SHALL sustain 1 byte/cycle when tx_ready stays high.
REQ-021 tx_data SHALL remain stable while tx_valid & !tx_ready.
REQ-022 Latency: req_valid first seen in IDLE at cycle N -> grant and req_ready at N+1 (output empty) -> tx_valid at N+2.
REQ-023 LINE_LOCK=0: OWN SHALL return to IDLE on the edge following each accepted byte.
REQ-024 LINE_LOCK=1: OWN SHALL return to IDLE on the edge following acceptance of byte 0x0A.
REQ-025 LINE_LOCK=1: an 8-bit-or-wider hold counter SHALL clear on each accepted byte and increment each OWN cycle with no accepted byte.
REQ-026 When the hold counter reaches MAX_HOLD-1 with no byte accepted, OWN SHALL return to IDLE, and hold_timeout SHALL pulse for exactly one cycle.
REQ-027 A byte accepted in the same cycle the hold limit is reached SHALL win: no timeout, and the counter clears.
REQ-028 Every release SHALL pass through IDLE for at least one cycle; last_owner SHALL update to the releasing owner.
REQ-029 A pending tx_valid byte SHALL NOT be dropped on release; it SHALL drain independently of grant.
REQ-030 The owner deasserting req_valid mid-line SHALL NOT release the grant except via REQ-026.

Reset
REQ-031 On rst_n low, the block SHALL asynchronously force state=IDLE, grant=0, req_ready=0, tx_valid=0, tx_data=0x00, hold counter=0, hold_timeout=0, last_owner=NUM_REQ-1.
REQ-032 Reset asserted mid-line SHALL discard the in-flight tx byte and ownership; the first post-reset arbitration SHALL favour requester 0.
REQ-033 Outputs SHALL hold reset values until the first rising clk edge after rst_n deasserts.

Verification
REQ-034 Req0 and req1 both streaming "AB\n" from reset, tx_ready=1 -> tx bytes 41,42,0A from req0, then 41,42,0A from req1; grant 01, 00, 10.
REQ-035 Single requester, 4 bytes, tx_ready low for 3 cycles on the 2nd byte -> tx_data holds 0x42 during the stall; no loss or duplication; req_ready low during the stall.
REQ-036 LINE_LOCK=1, MAX_HOLD=16; req1 sends "X" then stalls; req0 waiting -> hold_timeout pulses 16 cycles after the 'X' acceptance; grant moves to req0 after one IDLE cycle.
REQ-037 LINE_LOCK=0; three requesters continuously valid -> grant rotates 0,1,2,0,... one byte each, with an IDLE cycle between grants.
REQ-038 Assert rst_n low while tx_valid=1 mid-line, then release; req1 and req0 both valid -> all outputs zero during reset; req0 is granted first afterward.
